// File: rtl/rsb_ckpt.sv
// rtl/rsb_ckpt.sv - return stack buffer with speculative checkpoint/restore
module rsb_ckpt #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 64,
    parameter int NCKPT  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [ADDR_W-1:0]          push_addr_i,
    input  logic                       pop_i,
    input  logic                       ckpt_req_i,
    output logic                       ckpt_gnt_o,
    output logic [$clog2(NCKPT)-1:0]   ckpt_id_o,
    input  logic                       restore_i,
    input  logic [$clog2(NCKPT)-1:0]   restore_id_i,
    input  logic                       release_i,
    input  logic [$clog2(NCKPT)-1:0]   release_id_i,
    output logic [ADDR_W-1:0]          top_o,
    output logic                       top_valid_o,
    output logic [$clog2(DEPTH):0]     depth_o,
    output logic [$clog2(NCKPT):0]     ckpt_free_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);
    localparam int SP_W   = $clog2(DEPTH);
    localparam int CNT_W  = SP_W + 1;
    localparam int ID_W   = $clog2(NCKPT);
    localparam int FREE_W = ID_W + 1;

    logic [ADDR_W-1:0] stack [DEPTH];
    logic [SP_W-1:0]   sp;
    logic [CNT_W-1:0]  count;

    logic [NCKPT-1:0]  ck_valid;
    logic [SP_W-1:0]   ck_sp      [NCKPT];
    logic [CNT_W-1:0]  ck_count   [NCKPT];
    logic [ADDR_W-1:0] ck_top     [NCKPT];
    logic [NCKPT-1:0]  ck_younger [NCKPT];

    logic [SP_W-1:0]   sp_m1;
    logic              empty, full, do_push, do_pop, replace, restore_ok, release_ok;
    logic [ID_W-1:0]   gnt_id;
    logic [FREE_W-1:0] free_cnt;
    logic [NCKPT-1:0]  free_mask, valid_n;
    logic [NCKPT-1:0]  younger_n  [NCKPT];
    logic [SP_W-1:0]   wr_idx;

    assign sp_m1       = sp - SP_W'(1);
    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(DEPTH));
    assign top_o       = empty ? '0 : stack[sp_m1];
    assign top_valid_o = !empty;
    assign depth_o     = count;

    // A restore owns the cycle: stack ops are dropped even if the slot is stale.
    assign do_push     = push_i & !restore_i;
    assign do_pop      = pop_i & !restore_i;
    assign replace     = do_push & do_pop & !empty;
    assign wr_idx      = replace ? sp_m1 : sp;
    assign overflow_o  = do_push & !do_pop & full;
    assign underflow_o = do_pop & empty;
    assign restore_ok  = restore_i & ck_valid[restore_id_i];
    assign release_ok  = release_i & ck_valid[release_id_i];

    always_comb begin
        gnt_id   = '0;
        free_cnt = '0;
        for (int i = NCKPT - 1; i >= 0; i--) begin
            if (!ck_valid[i]) gnt_id = ID_W'(i);
            free_cnt = free_cnt + FREE_W'(!ck_valid[i]);
        end
    end

    assign ckpt_free_o = free_cnt;
    assign ckpt_gnt_o  = ckpt_req_i & (free_cnt != '0) & !restore_i;
    assign ckpt_id_o   = gnt_id;

    always_comb begin
        free_mask = '0;
        if (restore_ok) free_mask = (NCKPT'(1) << restore_id_i) | ck_younger[restore_id_i];
        if (release_ok) free_mask = free_mask | (NCKPT'(1) << release_id_i);
        valid_n = ck_valid & ~free_mask;
        for (int i = 0; i < NCKPT; i++) begin
            younger_n[i] = ck_younger[i] & ~free_mask;
        end
        if (ckpt_gnt_o) begin
            for (int i = 0; i < NCKPT; i++) begin
                if (valid_n[i]) younger_n[i][gnt_id] = 1'b1;
            end
            younger_n[gnt_id] = '0;
            valid_n[gnt_id]   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp       <= '0;
            count    <= '0;
            ck_valid <= '0;
            for (int i = 0; i < NCKPT; i++) ck_younger[i] <= '0;
        end else begin
            if (restore_ok) begin
                sp    <= ck_sp[restore_id_i];
                count <= ck_count[restore_id_i];
            end else if (do_push && !replace) begin
                sp <= sp + SP_W'(1);
                if (!full) count <= count + CNT_W'(1);
            end else if (do_pop && !do_push && !empty) begin
                sp    <= sp_m1;
                count <= count - CNT_W'(1);
            end
            ck_valid <= valid_n;
            for (int i = 0; i < NCKPT; i++) ck_younger[i] <= younger_n[i];
        end
    end

    // Restoring the saved top undoes a pop-then-push that clobbered the entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (restore_ok) begin
                if (ck_count[restore_id_i] != '0)
                    stack[ck_sp[restore_id_i] - SP_W'(1)] <= ck_top[restore_id_i];
            end else if (do_push) begin
                stack[wr_idx] <= push_addr_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && ckpt_gnt_o) begin
            ck_sp[gnt_id]    <= sp;
            ck_count[gnt_id] <= count;
            ck_top[gnt_id]   <= top_o;
        end
    end
endmodule

// File: doc/rsb_ckpt.md
# rsb_ckpt

Parametrised return stack buffer with speculative checkpoint/restore for the branch-prediction frontend. It predicts RET targets, handles CALL/RET in the same cycle, and wraps on overflow. It also snapshots pointer state plus the top entry for each in-flight branch, so a mispredict flush repairs the stack in one cycle. It sits beside the direction/target predictors in `rtl/bp`, fed by the fetch-stage call/return decoder and the branch-resolution unit.

## Interface
- `DEPTH`, 32: stack entries; power of two, ≥4.
- `ADDR_W`, 64: return-address width.
- `NCKPT`, 8: checkpoint slots; ≥2.
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `push_i`  in  1  CALL: push `push_addr_i`.
- `push_addr_i`  in  ADDR_W  return address to push.
- `pop_i`  in  1  RET: pop top.
- `ckpt_req_i`  in  1  request a checkpoint this cycle.
- `ckpt_gnt_o`  out  1  checkpoint taken this cycle (combinational).
- `ckpt_id_o`  out  $clog2(NCKPT)  slot granted; valid when `ckpt_gnt_o`.
- `restore_i`  in  1  mispredict: restore from `restore_id_i`.
- `restore_id_i`  in  $clog2(NCKPT)  checkpoint to restore.
- `release_i`  in  1  branch retired: free `release_id_i`.
- `release_id_i`  in  $clog2(NCKPT)  checkpoint to free.
- `top_o`  out  ADDR_W  predicted return address; 0 when empty.
- `top_valid_o`  out  1  count ≠ 0.
- `depth_o`  out  $clog2(DEPTH)+1  current occupancy.
- `ckpt_free_o`  out  $clog2(NCKPT)+1  number of free checkpoint slots.
- `overflow_o`  out  1  push dropped the oldest entry (combinational).
- `underflow_o`  out  1  pop attempted while empty (combinational).

## Operation
- **State:**
  - `sp` is a $clog2(DEPTH)-bit pointer to the next free slot and wraps modulo DEPTH.
  - `count` runs 0..DEPTH.
  - The entry array is not reset.
  - Each checkpoint slot holds `{valid, sp, count, top}` plus a NCKPT-bit `younger` mask.
- **top_o:** `count==0 ? 0 : stack[sp-1]`, read combinationally from registered state.
- **Push only:**
  - Write `stack[sp]`; `sp+1`.
  - `count` saturates at DEPTH; the oldest entry is overwritten.
  - `overflow_o=1` iff `count==DEPTH`.
- **Pop only:**
  - If `count≠0`: `sp-1`, `count-1`.
  - If `count==0`: no state change, `underflow_o=1`.
- **Push+pop, count≠0:** `stack[sp-1]=push_addr_i`; `sp` and `count` unchanged; no flags.
- **Push+pop, count==0:** acts as push; `underflow_o=1`.
- **Checkpoint:**
  - `ckpt_gnt_o = ckpt_req_i & any_free & !restore_i`.
  - `ckpt_id_o` = lowest-index free slot.
  - On grant, the slot captures the pre-update `sp`, `count` and `top_o` of this cycle; same-cycle push/pop are excluded from the snapshot.
  - The new slot's `younger` mask clears.
  - The new slot's bit is set in `younger` of every currently valid slot.
- **Restore** (`restore_i`, slot r valid):
  - Next `sp`/`count` = saved values.
  - If saved count≠0, `stack[saved_sp-1] = saved top`; this repairs a pop-then-push overwrite.
  - Same-cycle push, pop and checkpoint grant are ignored; `overflow_o`/`underflow_o` forced 0.
  - Slot r and every slot in `younger[r]` become free.
  - Restore of an invalid slot is a no-op for both stack and checkpoints.
- **Release** (`release_i`):
  - Frees `release_id_i` and clears its bit in all `younger` masks.
  - Release of an invalid slot is ignored.
  - Release combined with restore applies both frees.
- **Free-slot timing:** slots freed in a cycle become grantable the next cycle.
- **Reset:**
  - `sp=0`, `count=0`, all checkpoints invalid, all masks 0.
  - Outputs after reset: `top_o=0`, `top_valid_o=0`, `depth_o=0`, `ckpt_free_o=NCKPT`.
  - Combinational outputs follow inputs: `ckpt_gnt_o` = `ckpt_req_i`; `overflow_o`/`underflow_o` = 0 unless requested.
  - `rst` overrides every input in the same cycle.
  - Reset mid-operation discards all checkpoints.

## Timing
- Push, pop, restore and release update state at the rising edge; the effect is visible on `top_o`/`depth_o`/`ckpt_free_o` the next cycle.
- `ckpt_gnt_o`, `ckpt_id_o`, `overflow_o` and `underflow_o` are combinational from inputs and current state.
- No backpressure on push/pop; one push or pop per cycle is sustainable indefinitely.
- The checkpoint snapshot reflects the state before the grant cycle's stack operation.
- Restore completes in one cycle; the cycle after restore the stack is exactly the checkpointed state.

## Test plan
- **Reset, push, pop:** reset, push 0x1000, 0x2000 → `top_o=0x2000`, `depth_o=2`; pop → `top_o=0x1000`; pop, pop → second pop has `underflow_o=1`, `depth_o=0`, `top_o=0`.
- **Overflow wrap:** push DEPTH+1 addresses 0x10·k (k=1..33) → `overflow_o=1` on 33rd, `depth_o=32`; 32 pops return 0x210 down to 0x20.
- **Simultaneous push+pop:** stack [A,B]; push C + pop together → `top_o=C`, `depth_o=2`; on empty stack → `underflow_o=1`, `top_o=C`, `depth_o=1`.
- **Checkpoint repair:** stack [A,B], checkpoint → id 0; pop, push X, push Y; restore 0 → `top_o=B`, `depth_o=2`, `ckpt_free_o=NCKPT`.
- **Nested restore and release:**
  - Take checkpoints 0,1,2 in order; restore 1 → slots 1,2 freed, slot 0 still valid, `ckpt_free_o=NCKPT-1`.
  - Release 0 → `ckpt_free_o=NCKPT`.
  - Restore of freed slot 2 → no state change.
- **Exhaustion and priority:**
  - Allocate NCKPT checkpoints → next `ckpt_req_i` gets `ckpt_gnt_o=0`.
  - Release 3 → grant next cycle with `ckpt_id_o=3`.
  - `restore_i` together with `push_i`/`ckpt_req_i` → push ignored, no grant.
